count60_down: RTL and testbench

Two-digit BCD countdown timer, 59..00, for the clock/timer datapath. It is the decrementing counterpart of the team's mod-60 up counter: it loads a preset minute/second value and counts down one step per `en` tick. Depending on `WRAP`, it either stops at 00 and raises `done`, or wraps to 59 and pulses `bo`. Its outputs share the up counter's digit format, so both can drive the same display decoder.

---
 rtl/timer_pkg.sv | 18 +
 rtl/bcd_down_digit.sv | 36 +++
 rtl/count60_down.sv | 116 +++++++++++
 tb/tb_count60_down.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD timer datapath.
package timer_pkg;

  // Width of one BCD digit.
  localparam int DIGIT_W = 4;

  // Largest value each digit of a mod-60 value can hold.
  localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;

  // Countdown controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cd_state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit. It wraps from 0 to MAX on a decrement,
// and a preset value above MAX is clamped to MAX when it is loaded.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = ONES_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               zero
);

  logic [DIGIT_W-1:0] digit_reg;
  logic [DIGIT_W-1:0] load_clamped;

  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  // Digit register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_reg <= '0;
    end else if (load) begin
      digit_reg <= load_clamped;
    end else if (dec) begin
      digit_reg <= (digit_reg == '0) ? MAX : digit_reg - 1'b1;
    end
  end

  assign digit = digit_reg;
  assign zero  = (digit_reg == '0);

endmodule

// File: rtl/count60_down.sv
// Two-digit BCD countdown timer (59..00). It either stops at 00 and holds
// done, or wraps to 59 and pulses bo, depending on WRAP.
module count60_down
  import timer_pkg::*;
#(
  parameter bit WRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_ones,
  input  logic [3:0] load_tens,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] count1,
  output logic [3:0] count2,
  output logic       bo,
  output logic       done,
  output logic       busy
);

  cd_state_t state_reg;
  logic      bo_reg;
  logic      done_reg;
  logic      ones_zero;
  logic      tens_zero;
  logic      at_zero;
  logic      at_one;
  logic      run_step;
  logic      dec_ones;
  logic      dec_tens;

  assign at_zero  = ones_zero && tens_zero;
  assign at_one   = (count1 == 4'd1) && tens_zero;

  // A counted tick: RUN, enabled, and not overridden by load or stop.
  assign run_step = (state_reg == RUN) && !load && !stop && en;

  // In stop-at-zero mode the value never moves below 00.
  assign dec_ones = run_step && (WRAP || !at_zero);

  // Tens borrows only when ones rolls over from 0 to 9.
  assign dec_tens = dec_ones && ones_zero;

  bcd_down_digit #(.MAX(ONES_MAX)) u_ones (
    .clk      (clk),
    .rst      (rst),
    .dec      (dec_ones),
    .load     (load),
    .load_val (load_ones),
    .digit    (count1),
    .zero     (ones_zero)
  );

  bcd_down_digit #(.MAX(TENS_MAX)) u_tens (
    .clk      (clk),
    .rst      (rst),
    .dec      (dec_tens),
    .load     (load),
    .load_val (load_tens),
    .digit    (count2),
    .zero     (tens_zero)
  );

  // Control FSM with registered borrow pulse and terminal-count flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      bo_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      bo_reg <= 1'b0;
      if (load) begin
        state_reg <= IDLE;
        done_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (!stop && start) begin
              if (!WRAP && at_zero) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end else begin
                state_reg <= RUN;
              end
            end
          end
          RUN: begin
            if (stop) begin
              state_reg <= IDLE;
            end else if (en) begin
              if (WRAP && at_zero) begin
                bo_reg <= 1'b1;
              end else if (!WRAP && (at_one || at_zero)) begin
                state_reg <= DONE;
                done_reg  <= 1'b1;
              end
            end
          end
          DONE: begin
            state_reg <= DONE;
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign bo   = WRAP ? bo_reg : 1'b0;
  assign done = WRAP ? 1'b0 : done_reg;
  assign busy = (state_reg == RUN);

endmodule

// File: tb/tb_count60_down.sv
// Bench for count60_down: both WRAP settings side by side, driven by the
// same directed sequence and then random stimulus, checked each cycle
// against an integer-valued model of the timer.
module tb_count60_down;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] load_ones = 4'd0;
  logic [3:0] load_tens = 4'd0;

  logic [3:0] c1_0, c2_0, c1_1, c2_1;
  logic       bo_0, done_0, busy_0, bo_1, done_1, busy_1;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  count60_down #(.WRAP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_ones(load_ones), .load_tens(load_tens),
    .start(start), .stop(stop),
    .count1(c1_0), .count2(c2_0), .bo(bo_0), .done(done_0), .busy(busy_0)
  );

  count60_down #(.WRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_ones(load_ones), .load_tens(load_tens),
    .start(start), .stop(stop),
    .count1(c1_1), .count2(c2_1), .bo(bo_1), .done(done_1), .busy(busy_1)
  );

  // Model: value is a plain integer 0..59; st 0=idle, 1=running, 2=finished.
  typedef struct {
    int v;
    int st;
    bit bo;
    bit dn;
  } mod_t;

  mod_t m0, m1;

  function automatic mod_t mstep(mod_t s, bit wrap);
    mod_t n;
    int lo, lt;
    n = s;
    n.bo = 1'b0;
    lo = (load_ones > 4'd9) ? 9 : int'(load_ones);
    lt = (load_tens > 4'd5) ? 5 : int'(load_tens);
    if (rst) begin
      n.v = 0; n.st = 0; n.dn = 1'b0;
    end else if (load) begin
      n.v = lt * 10 + lo; n.st = 0; n.dn = 1'b0;
    end else if (s.st == 0) begin
      if (start && !stop) begin
        if (!wrap && s.v == 0) begin
          n.st = 2; n.dn = 1'b1;
        end else begin
          n.st = 1;
        end
      end
    end else if (s.st == 1) begin
      if (stop) begin
        n.st = 0;
      end else if (en) begin
        if (s.v == 0) begin
          if (wrap) begin
            n.v = 59; n.bo = 1'b1;
          end else begin
            n.st = 2; n.dn = 1'b1;
          end
        end else begin
          n.v = s.v - 1;
          if (!wrap && n.v == 0) begin
            n.st = 2; n.dn = 1'b1;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] mexp(mod_t s);
    return {4'(s.v / 10), 4'(s.v % 10), s.bo, s.dn, (s.st == 1)};
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, 1'b0);
    m1 <= mstep(m1, 1'b1);
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ({c2_0, c1_0, bo_0, done_0, busy_0} !== mexp(m0)) begin
        failures++;
        $display("FAIL model_wrap0 t=%0t got c2c1bo_done_busy=%b want %b",
                 $time, {c2_0, c1_0, bo_0, done_0, busy_0}, mexp(m0));
      end
      checks++;
      if ({c2_1, c1_1, bo_1, done_1, busy_1} !== mexp(m1)) begin
        failures++;
        $display("FAIL model_wrap1 t=%0t got c2c1bo_done_busy=%b want %b",
                 $time, {c2_1, c1_1, bo_1, done_1, busy_1}, mexp(m1));
      end
    end
  end

  task automatic cyc(input bit r, input bit l, input bit sa, input bit sp,
                     input bit e, input logic [3:0] lo, input logic [3:0] lt);
    rst = r; load = l; start = sa; stop = sp; en = e;
    load_ones = lo; load_tens = lt;
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectation for one instance after the last cycle.
  task automatic chk(input string nm, input bit w, input int val,
                     input bit b, input bit d, input bit bz);
    logic [10:0] act, req;
    req = {4'(val / 10), 4'(val % 10), b, d, bz};
    act = w ? {c2_1, c1_1, bo_1, done_1, busy_1}
            : {c2_0, c1_0, bo_0, done_0, busy_0};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s wrap%0d got %0d%0d bo=%b done=%b busy=%b want %02d bo=%b done=%b busy=%b",
               nm, w, act[10:7], act[6:3], act[2], act[1], act[0], val, b, d, bz);
    end else begin
      $display("ok   %s wrap%0d value=%02d bo=%b done=%b busy=%b", nm, w, val, b, d, bz);
    end
  endtask

  initial begin
    // Reset
    cyc(1, 0, 0, 0, 0, 4'd0, 4'd0);
    armed = 1'b1;
    chk("reset", 0, 0, 0, 0, 0);
    chk("reset", 1, 0, 0, 0, 0);

    // Load 32, start, five ticks
    cyc(0, 1, 0, 0, 0, 4'd2, 4'd3);
    chk("load32", 0, 32, 0, 0, 0);
    chk("load32", 1, 32, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 4'd0, 4'd0);
    chk("start32", 0, 32, 0, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
      chk("count", 0, 32 - i, 0, 0, 1);
      chk("count", 1, 32 - i, 0, 0, 1);
    end

    // Terminal count vs wrap from 02
    cyc(0, 1, 0, 0, 0, 4'd2, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("to01", 0, 1, 0, 0, 1);
    chk("to01", 1, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("to00_done", 0, 0, 0, 1, 0);
    chk("to00_run", 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("hold00", 0, 0, 0, 1, 0);
    chk("wrap59", 1, 59, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("hold00b", 0, 0, 0, 1, 0);
    chk("after59", 1, 58, 0, 0, 1);

    // Stop/start interplay from 45
    cyc(0, 1, 0, 0, 0, 4'd5, 4'd4);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("run42", 0, 42, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 4'd0, 4'd0);
    chk("stop42", 0, 42, 0, 0, 0);
    chk("stop42", 1, 42, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 4'd0, 4'd0);
    chk("restart42", 0, 42, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("resume41", 1, 41, 0, 0, 1);

    // Clamp, then load mid-run
    cyc(0, 1, 0, 0, 0, 4'hF, 4'h9);
    chk("clamp59", 0, 59, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 4'hC, 4'h7);
    chk("clamp59b", 1, 59, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("dec58", 0, 58, 0, 0, 1);
    cyc(0, 1, 1, 0, 1, 4'd0, 4'd1);
    chk("loadrun10", 0, 10, 0, 0, 0);
    chk("loadrun10", 1, 10, 0, 0, 0);

    // Reset mid-run at 37
    cyc(0, 1, 0, 0, 0, 4'd7, 4'd3);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0);
    chk("run37", 1, 37, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("rst_run", 0, 0, 0, 0, 0);
    chk("rst_run", 1, 0, 0, 0, 0);

    // Start at 00
    cyc(0, 1, 0, 0, 0, 4'd0, 4'd0);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0);
    chk("start00", 0, 0, 0, 1, 0);
    chk("start00", 1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0);
    chk("done_hold", 0, 0, 0, 1, 0);
    chk("wrap_from00", 1, 59, 1, 0, 1);
    cyc(0, 0, 1, 1, 1, 4'd0, 4'd0);
    chk("done_ignores", 0, 0, 0, 1, 0);
    chk("stop_wins", 1, 59, 0, 0, 0);

    // Randomized phase, checked by the model compare process
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 5,
          $urandom_range(0, 99) < 70,
          4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)));
    end
    cyc(0, 0, 0, 0, 0, 4'd0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
